pmc_snapshot_writer: RTL and testbench
======================================

PMC_SNAPSHOT_WRITER -- requirements
Module: pmc_snapshot_writer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0F00, SHALL be the byte address of snapshot word 0.
REQ-002 Parameter WORDS, fixed at 5, SHALL be the snapshot length in 32-bit words.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-005 snap_req  in  1  SHALL be the single-cycle snapshot request.
REQ-006 stall_count_in  in  256  SHALL be the stall counter bus.
REQ-007 cycles_per_instruction_q78_in  in  256  SHALL be the CPI bus, Q7.8 format in bits [15:0].
REQ-008 arith_count_in  in  256  SHALL be the arithmetic-operation counter bus.
REQ-009 mem_access_count_in  in  256  SHALL be the memory-access counter bus.
REQ-010 mem_we  out  1  SHALL be the data-memory write request.
REQ-011 mem_addr  out  32  SHALL be the byte write address.
REQ-012 mem_wdata  out  32  SHALL be the write data.
REQ-013 mem_gnt  in  1  SHALL be the grant; a word completes on a clk edge where mem_we and mem_gnt are both 1.
REQ-014 busy  out  1  SHALL be 1 whenever the state is not IDLE.
REQ-015 done  out  1  SHALL be a one-cycle pulse after the last word completes.
REQ-016 trunc  out  1  SHALL be a sticky flag indicating that a captured bus had nonzero discarded upper bits.
REQ-017 overrun  out  1  SHALL be a sticky flag indicating that a request was dropped.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, WRITE and DONE.
REQ-019 IDLE + snap_req=1 SHALL capture five words on that edge, clear idx to 0 and enter WRITE.
- Word 0 = seq.
- Word 1 = stall_count_in[31:0].
- Word 2 = {16'b0, cycles_per_instruction_q78_in[15:0]}.
- Word 3 = arith_count_in[31:0].
- Word 4 = mem_access_count_in[31:0].
REQ-020 The capture SHALL increment the 32-bit seq after latching it, wrapping from FFFF_FFFF to 0.
REQ-021 In WRITE, the block SHALL drive mem_we=1, mem_addr=BASE_ADDR+4*idx and mem_wdata=word[idx].
REQ-022 In WRITE, all three outputs SHALL be held stable while mem_gnt=0, for an unbounded time.
REQ-023 WRITE + mem_gnt=1 with idx<4 SHALL increment idx; with idx=4 it SHALL enter DONE.
REQ-024 DONE SHALL assert done=1 and mem_we=0 for exactly one cycle, then return to IDLE.
REQ-025 snap_req=1 in WRITE or DONE SHALL be ignored: no recapture, no seq change, and overrun set to 1.
REQ-026 Capture SHALL set trunc=1 in either case:
- any of bits [255:32] of stall, arith or mem_access is nonzero;
- any of bits [255:16] of the CPI bus is nonzero.
REQ-027 trunc and overrun SHALL clear only on reset.
REQ-028 The latency from the snap_req edge to the first mem_we=1 SHALL be one cycle.
REQ-029 With mem_gnt tied to 1, the first mem_we=1 through the done pulse SHALL take exactly 6 cycles.
REQ-030 In IDLE, mem_we SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-031 Input buses SHALL be sampled only at capture; changes during WRITE SHALL NOT affect written data.

Reset
REQ-032 reset=1 SHALL, on the next edge, force the following:
- state=IDLE and idx=0;
- seq=0 and the snapshot registers=0;
- mem_we=0, mem_addr=0, mem_wdata=0;
- busy=0, done=0, trunc=0, overrun=0.
REQ-033 reset asserted mid-WRITE SHALL abort the transfer with no further mem_we, including when mem_gnt=1 on the same edge.
REQ-034 reset SHALL take priority over a coincident snap_req.

Verification
REQ-035 Basic transfer: gnt=1, stall=7, CPI=16'h0280, arith=100, mem=42, snap_req pulse.
- Required: writes to F00..F10 of 0, 7, 0x280, 100, 42; done on cycle 7; seq=1.
REQ-036 Backpressure: gnt=0 for 3 cycles on word 2.
- Required: addr F08 and data 0x280 held for 4 cycles; total cycles = 9.
REQ-037 Dropped request: snap_req during WRITE idx=1, and again on the done cycle.
- Required: overrun=1; exactly 5 writes; seq=1.
REQ-038 Sequence and trunc: a second snapshot with arith bit 40 set.
- Required: word 0 = 1, word 3 = low 32 bits, trunc=1.
REQ-039 Abort and restart: reset at idx=2 with gnt=1.
- Required: no further mem_we; all outputs 0.
- A following snap_req SHALL restart at F00 with seq word 0.

Source files
------------

// File: rtl/pmc_snapshot_writer.sv
// Captures a five-word performance-counter snapshot on request and streams it
// to data memory one word per granted cycle, then pulses done.
module pmc_snapshot_writer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0F00,
  parameter int          WORDS     = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         snap_req,
  input  logic [255:0] stall_count_in,
  input  logic [255:0] cycles_per_instruction_q78_in,
  input  logic [255:0] arith_count_in,
  input  logic [255:0] mem_access_count_in,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic         mem_gnt,
  output logic         busy,
  output logic         done,
  output logic         trunc,
  output logic         overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [2:0] LAST_IDX = 3'(WORDS - 1);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] seq_q, seq_d;
  logic        trunc_q, trunc_d;
  logic        overrun_q, overrun_d;
  logic        capture;
  logic        upper_nz;

  logic [31:0] words_q   [WORDS];
  logic [31:0] cap_words [WORDS];

  // Word 0 carries the sequence number as it stood before this capture.
  assign cap_words[0] = seq_q;
  assign cap_words[1] = stall_count_in[31:0];
  assign cap_words[2] = {16'b0, cycles_per_instruction_q78_in[15:0]};
  assign cap_words[3] = arith_count_in[31:0];
  assign cap_words[4] = mem_access_count_in[31:0];

  assign upper_nz = (|stall_count_in[255:32])
                  | (|cycles_per_instruction_q78_in[255:16])
                  | (|arith_count_in[255:32])
                  | (|mem_access_count_in[255:32]);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    trunc_d   = trunc_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    done      = 1'b0;
    busy      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (snap_req) begin
          capture = 1'b1;
          idx_d   = 3'd0;
          seq_d   = seq_q + 32'd1;
          trunc_d = trunc_q | upper_nz;
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = BASE_ADDR + {27'b0, idx_q, 2'b00};
        mem_wdata = words_q[idx_q];
        if (mem_gnt) begin
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + 3'd1;
        end
        if (snap_req) overrun_d = 1'b1;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
        if (snap_req) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      seq_q     <= 32'h0;
      trunc_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < WORDS; i++) words_q[i] <= 32'h0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      trunc_q   <= trunc_d;
      overrun_q <= overrun_d;
      if (capture) begin
        for (int i = 0; i < WORDS; i++) words_q[i] <= cap_words[i];
      end
    end
  end

  assign trunc   = trunc_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_pmc_snapshot_writer.sv
// Bench for pmc_snapshot_writer: queue-based transaction model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_pmc_snapshot_writer;

  localparam logic [31:0] BASE = 32'h0000_0F00;

  logic         clk = 1'b0;
  logic         reset, snap_req, mem_gnt;
  logic [255:0] stall, cpi, arith, memc;
  logic         mem_we, busy, done, trunc, overrun;
  logic [31:0]  mem_addr, mem_wdata;

  always #5 clk = ~clk;

  pmc_snapshot_writer #(.BASE_ADDR(BASE), .WORDS(5)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .snap_req                     (snap_req),
    .stall_count_in               (stall),
    .cycles_per_instruction_q78_in(cpi),
    .arith_count_in               (arith),
    .mem_access_count_in          (memc),
    .mem_we                       (mem_we),
    .mem_addr                     (mem_addr),
    .mem_wdata                    (mem_wdata),
    .mem_gnt                      (mem_gnt),
    .busy                         (busy),
    .done                         (done),
    .trunc                        (trunc),
    .overrun                      (overrun)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: outstanding writes as a queue of (addr, data), a pending done pulse,
  // sequence counter and sticky flags.
  logic [31:0] m_addr[$];
  logic [31:0] m_data[$];
  bit          m_done  = 1'b0;
  logic [31:0] m_seq   = 32'h0;
  bit          m_trunc = 1'b0;
  bit          m_over  = 1'b0;
  bit          model_en = 1'b0;

  // Observed traffic for the directed scenarios.
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          first_we_cyc = -1;
  int          done_cyc = -1;
  bit          done_seen = 1'b0;
  int          hold_cnt = 0;
  int          t0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    bit          idle;
    bit          nd;
    logic [31:0] snap [5];
    if (model_en) begin
      check("mem_we",    32'(mem_we),    32'(m_addr.size() > 0));
      check("mem_addr",  mem_addr,       (m_addr.size() > 0) ? m_addr[0] : 32'h0);
      check("mem_wdata", mem_wdata,      (m_data.size() > 0) ? m_data[0] : 32'h0);
      check("busy",      32'(busy),      32'((m_addr.size() > 0) || m_done));
      check("done",      32'(done),      32'(m_done));
      check("trunc",     32'(trunc),     32'(m_trunc));
      check("overrun",   32'(overrun),   32'(m_over));
    end
    if (mem_we === 1'b1 && mem_gnt) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
    if (mem_we === 1'b1 && first_we_cyc < 0) first_we_cyc = cyc;
    if (done === 1'b1 && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    if (mem_we === 1'b1 && mem_addr == BASE + 32'd8 && mem_wdata == 32'h280) hold_cnt++;

    // Advance the model using the inputs the DUT samples on the next edge.
    if (reset) begin
      m_addr.delete();
      m_data.delete();
      m_done  = 1'b0;
      m_seq   = 32'h0;
      m_trunc = 1'b0;
      m_over  = 1'b0;
    end else begin
      idle = (m_addr.size() == 0) && !m_done;
      nd   = 1'b0;
      if (m_addr.size() > 0 && mem_gnt) begin
        void'(m_addr.pop_front());
        void'(m_data.pop_front());
        if (m_addr.size() == 0) nd = 1'b1;
      end
      if (snap_req) begin
        if (idle) begin
          snap[0] = m_seq;
          snap[1] = stall[31:0];
          snap[2] = {16'h0, cpi[15:0]};
          snap[3] = arith[31:0];
          snap[4] = memc[31:0];
          for (int k = 0; k < 5; k++) begin
            m_addr.push_back(BASE + 32'(4 * k));
            m_data.push_back(snap[k]);
          end
          m_seq = m_seq + 32'd1;
          if ((stall >> 32) != 0 || (cpi >> 16) != 0 || (arith >> 32) != 0 || (memc >> 32) != 0)
            m_trunc = 1'b1;
        end else begin
          m_over = 1'b1;
        end
      end
      m_done = nd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_snap();
    log_addr.delete();
    log_data.delete();
    first_we_cyc = -1;
    done_seen    = 1'b0;
    done_cyc     = -1;
    hold_cnt     = 0;
    t0           = cyc;
    snap_req     = 1'b1;
    step();
    snap_req     = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (!done_seen && n < maxc) begin
      step();
      n++;
    end
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, required a done pulse", maxc);
    end
  endtask

  initial begin
    logic [31:0] exp1 [5];
    int          n_before;
    exp1[0] = 32'd0; exp1[1] = 32'd7; exp1[2] = 32'h280; exp1[3] = 32'd100; exp1[4] = 32'd42;

    reset = 1'b1; snap_req = 1'b0; mem_gnt = 1'b1;
    stall = '0; cpi = '0; arith = '0; memc = '0;
    step();
    model_en = 1'b1;
    step();
    reset = 1'b0;
    check("reset_busy",    32'(busy),      32'd0);
    check("reset_we",      32'(mem_we),    32'd0);
    check("reset_addr",    mem_addr,       32'd0);
    check("reset_trunc",   32'(trunc),     32'd0);
    check("reset_overrun", 32'(overrun),   32'd0);

    // Basic transfer.
    stall = 256'd7; cpi = 256'h0280; arith = 256'd100; memc = 256'd42;
    start_snap();
    wait_done(20);
    step();
    check("t1_nwrites", 32'(log_addr.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check("t1_addr", log_addr[k], 32'hF00 + 32'(4 * k));
      check("t1_data", log_data[k], exp1[k]);
    end
    check("t1_done_cycle", 32'(done_cyc - t0 + 1), 32'd7);
    check("t1_latency",    32'(first_we_cyc - t0), 32'd1);
    check("t1_span",       32'(done_cyc - first_we_cyc + 1), 32'd6);
    check("t1_idle_busy",  32'(busy), 32'd0);

    // Second snapshot: sequence number and truncation.
    check("t4_trunc_before", 32'(trunc), 32'd0);
    arith = (256'd1 << 40) | 256'h1234;
    start_snap();
    wait_done(20);
    step();
    check("t4_word0", log_data[0], 32'd1);
    check("t4_word3", log_data[3], 32'h0000_1234);
    check("t4_trunc", 32'(trunc), 32'd1);
    arith = 256'd100;

    // Backpressure on word 2.
    start_snap();
    step();
    step();
    mem_gnt = 1'b0;
    step();
    step();
    step();
    mem_gnt = 1'b1;
    wait_done(30);
    step();
    check("t2_hold",    32'(hold_cnt), 32'd4);
    check("t2_total",   32'(done_cyc - first_we_cyc + 1), 32'd9);
    check("t2_nwrites", 32'(log_addr.size()), 32'd5);
    check("t2_word0",   log_data[0], 32'd2);

    // Dropped requests during WRITE and on the done cycle.
    check("t3_overrun_before", 32'(overrun), 32'd0);
    start_snap();
    step();
    snap_req = 1'b1;
    stall    = 256'd999;
    step();
    snap_req = 1'b0;
    step();
    step();
    step();
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    check("t3_done_hit", 32'(done_cyc - t0), 32'd6);
    step();
    step();
    step();
    check("t3_nwrites", 32'(log_addr.size()), 32'd5);
    check("t3_word0",   log_data[0], 32'd3);
    check("t3_word1",   log_data[1], 32'd7);
    check("t3_overrun", 32'(overrun), 32'd1);
    check("t3_busy",    32'(busy), 32'd0);
    start_snap();
    wait_done(20);
    step();
    check("t3_seq_kept", log_data[0], 32'd4);

    // Abort at idx=2 with grant high; reset also beats a coincident request.
    stall = 256'd7;
    start_snap();
    step();
    step();
    reset    = 1'b1;
    snap_req = 1'b1;
    step();
    reset    = 1'b0;
    snap_req = 1'b0;
    check("t5_we",      32'(mem_we),  32'd0);
    check("t5_addr",    mem_addr,     32'd0);
    check("t5_wdata",   mem_wdata,    32'd0);
    check("t5_busy",    32'(busy),    32'd0);
    check("t5_done",    32'(done),    32'd0);
    check("t5_trunc",   32'(trunc),   32'd0);
    check("t5_overrun", 32'(overrun), 32'd0);
    n_before = log_addr.size();
    for (int k = 0; k < 4; k++) step();
    check("t5_no_more_we", 32'(log_addr.size()), 32'(n_before));
    check("t5_aborted_at", 32'(n_before), 32'd3);
    start_snap();
    wait_done(20);
    step();
    check("t5_restart_addr", log_addr[0], 32'hF00);
    check("t5_restart_seq",  log_data[0], 32'd0);
    check("t5_nwrites",      32'(log_addr.size()), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
